uart_out_port_decode: RTL
=========================

// Module: uart_out_port_decode
// PURPOSE
//  Write-side port decoder between the TramelBlaze out_port/port_id/write_strobe bus and the UART transmitter.
//  Decodes processor writes into TX data, control and interrupt-mask registers.
//  TX bytes are buffered in a small FIFO and handed to the transmitter with a load/ready handshake.
//  Status flags (full/empty/overflow) feed the read-side input-port mux.
// PARAMETERS
//  DEPTH      4        TX FIFO entries; power of 2, >=2
//  AW         2        log2(DEPTH)
//  TX_ADDR    16'h0000 port_id for TX data push (out_port[7:0])
//  CTRL_ADDR  16'h0001 port_id for control register (out_port[7:0])
//  MASK_ADDR  16'h0002 port_id for interrupt mask register (out_port[7:0])
//  CLR_ADDR   16'h0003 port_id for overflow clear (data ignored)
// PORTS
//  clk           in   1     system clock; all logic on rising edge
//  reset         in   1     synchronous, active-high reset
//  port_id       in   16    TramelBlaze port address
//  out_port      in   16    TramelBlaze write data; bits [15:8] ignored
//  write_strobe  in   1     one-cycle write qualifier
//  tx_ready      in   1     transmitter idle and able to accept a byte
//  tx_data       out  8     byte presented to transmitter; registered
//  tx_load       out  1     one-cycle load pulse; tx_data valid while high
//  baud_sel      out  4     ctrl[7:4]
//  eight         out  1     ctrl[3]: 1 = 8 data bits, 0 = 7
//  pen           out  1     ctrl[2]: parity enable
//  ohel          out  1     ctrl[1]: 1 = odd parity, 0 = even
//  int_mask      out  8     interrupt mask register
//  fifo_full     out  1     count == DEPTH
//  fifo_empty    out  1     count == 0
//  overflow      out  1     sticky: push attempted while full
//  tx_count      out  AW+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset values: tx_data=0, tx_load=0, ctrl=8'h00, int_mask=8'h00, overflow=0, count=0,
//   FIFO pointers=0, FSM=IDLE. A mid-operation reset flushes the FIFO and aborts a pending load;
//   tx_load is low in the cycle after reset is sampled.
//  Decode: write = write_strobe & (port_id == X_ADDR); exact 16-bit match; unmatched addresses are ignored.
//  CTRL and MASK writes update the register on the next edge; outputs are register bits, no combinational path.
//  Push on a TX write: if not full, write out_port[7:0] at wr_ptr and increment count; if full, drop the byte and set overflow.
//  Simultaneous push and pop: push accepted even when full, count unchanged, no overflow.
//   When empty, a push cannot be popped in the same cycle; pop is at least 1 cycle later.
//  Pointers wrap modulo DEPTH; count is a separate AW+1 bit counter.
//  Overflow is cleared by a CLR_ADDR write. Set and clear in the same cycle -> set wins.
//  Handshake FSM:
//   IDLE: if !empty & tx_ready -> tx_data<=head, pop, go LOAD.
//   LOAD: tx_load=1 for exactly one cycle -> ACK.
//   ACK: wait for tx_ready==0, or 3 cycles elapsed (guard counter) -> IDLE.
//   IDLE then requires tx_ready==1 before the next pop.
//  Latency: push into an empty FIFO with tx_ready=1 -> tx_load asserts 2 cycles after the write edge.
//  tx_data holds its value until the next pop.
// STRUCTURE
//  Shared package: the four port-address constants; FSM state encoding IDLE=2'd0, LOAD=2'd1, ACK=2'd2;
//   ctrl bit-field positions.
//  Sub-module: uart_tx_fifo (sync FIFO, DEPTH/AW params, push/pop/full/empty/count).
//  Top level holds the decode, ctrl/mask/overflow registers and the handshake FSM.
// TESTING
//  1. Reset then idle -> all outputs 0; fifo_empty=1; tx_count=0.
//  2. Write 16'hAB55 to CTRL_ADDR -> baud_sel=5, eight=0, pen=1, ohel=0. Write 16'h00F0 to 16'h0009 -> no change.
//  3. tx_ready=1, write 8'hA5 to TX_ADDR -> tx_load 1-cycle pulse 2 cycles later, tx_data=8'hA5;
//     drop tx_ready the next cycle -> FSM returns to IDLE, fifo_empty=1.
//  4. tx_ready=0, write 5 bytes 8'h01..8'h05 -> tx_count=4, fifo_full=1, overflow=1.
//     Raise tx_ready -> loads 01,02,03,04 in order; CLR_ADDR write -> overflow=0.
//  5. Full FIFO with a pop and a TX write in the same cycle -> overflow stays 0, tx_count stays 4,
//     new byte delivered last.
//  6. Assert reset in the LOAD state with 3 bytes queued -> next cycle tx_load=0, tx_count=0,
//     ctrl=0, no further loads.

Source files
------------

// File: rtl/uart_out_port_decode_pkg.sv
// Shared constants for the TramelBlaze write-side UART port decoder.
// Port addresses, handshake FSM encoding and control-register bit positions.
package uart_out_port_decode_pkg;

    localparam logic [15:0] TX_ADDR   = 16'h0000;
    localparam logic [15:0] CTRL_ADDR = 16'h0001;
    localparam logic [15:0] MASK_ADDR = 16'h0002;
    localparam logic [15:0] CLR_ADDR  = 16'h0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } tx_state_e;

    localparam int CTRL_BAUD_LSB  = 4;
    localparam int CTRL_EIGHT_BIT = 3;
    localparam int CTRL_PEN_BIT   = 2;
    localparam int CTRL_OHEL_BIT  = 1;

    // ACK gives up waiting for tx_ready to drop after this many extra cycles (3 total)
    localparam logic [1:0] ACK_GUARD_MAX = 2'd2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; registered count, head visible combinationally from rd_ptr.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [7:0]    i_push_dat,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_out_port_decode.sv
// Decodes processor port writes into TX FIFO pushes, ctrl/mask regs and overflow clear.
// Push to tx_load is 2 cycles; bytes wait in the FIFO until the transmitter raises tx_ready.
module uart_out_port_decode
    import uart_out_port_decode_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          AW        = 2,
    parameter logic [15:0] P_TX_ADDR   = TX_ADDR,
    parameter logic [15:0] P_CTRL_ADDR = CTRL_ADDR,
    parameter logic [15:0] P_MASK_ADDR = MASK_ADDR,
    parameter logic [15:0] P_CLR_ADDR  = CLR_ADDR
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [15:0]   i_port_id,
    input  logic [15:0]   i_out_port,
    input  logic          i_write_strobe,
    input  logic          i_tx_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_load,
    output logic [3:0]    o_baud_sel,
    output logic          o_eight,
    output logic          o_pen,
    output logic          o_ohel,
    output logic [7:0]    o_int_mask,
    output logic          o_fifo_full,
    output logic          o_fifo_empty,
    output logic          o_overflow,
    output logic [AW:0]   o_tx_count
);

    logic       w_wr_tx;
    logic       w_wr_ctrl;
    logic       w_wr_mask;
    logic       w_wr_clr;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_load;
    logic       w_ovf_set;
    logic [7:0] w_head;
    logic       w_unused_bits;

    logic [7:0] r_ctrl;
    logic [7:0] r_int_mask;
    logic       r_overflow;
    logic [7:0] r_tx_data;
    logic       r_tx_load;
    logic [1:0] r_guard;
    tx_state_e  r_state;
    tx_state_e  w_state_nxt;

    assign w_wr_tx   = i_write_strobe & (i_port_id == P_TX_ADDR);
    assign w_wr_ctrl = i_write_strobe & (i_port_id == P_CTRL_ADDR);
    assign w_wr_mask = i_write_strobe & (i_port_id == P_MASK_ADDR);
    assign w_wr_clr  = i_write_strobe & (i_port_id == P_CLR_ADDR);
    // A push into a full FIFO is only lost if no pop frees a slot in the same cycle
    assign w_ovf_set = w_wr_tx & w_full & ~w_pop;
    assign w_unused_bits = ^{i_out_port[15:8], r_ctrl[0]};

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_wr_tx),
        .i_push_dat (i_out_port[7:0]),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (o_tx_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl     <= 8'h00;
            r_int_mask <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_ctrl     <= i_out_port[7:0];
            if (w_wr_mask) r_int_mask <= i_out_port[7:0];
            if (w_ovf_set)     r_overflow <= 1'b1;
            else if (w_wr_clr) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_guard   <= 2'd0;
            r_tx_data <= 8'h00;
            r_tx_load <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_guard   <= (r_state == ST_ACK) ? r_guard + 2'd1 : 2'd0;
            r_tx_load <= w_load;
            if (w_pop) r_tx_data <= w_head;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pop) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_ACK;
            ST_ACK:  if (!i_tx_ready || r_guard == ACK_GUARD_MAX) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop  = 1'b0;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: w_pop  = ~w_empty & i_tx_ready;
            ST_LOAD: w_load = 1'b1;
            default: begin
                w_pop  = 1'b0;
                w_load = 1'b0;
            end
        endcase
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_load    = r_tx_load;
    assign o_baud_sel   = r_ctrl[CTRL_BAUD_LSB +: 4];
    assign o_eight      = r_ctrl[CTRL_EIGHT_BIT];
    assign o_pen        = r_ctrl[CTRL_PEN_BIT];
    assign o_ohel       = r_ctrl[CTRL_OHEL_BIT];
    assign o_int_mask   = r_int_mask;
    assign o_fifo_full  = w_full;
    assign o_fifo_empty = w_empty;
    assign o_overflow   = r_overflow;

endmodule
